// File: rtl/sram_fifo_pkg.sv
// Shared sizing and types for the SRAM-backed FIFO controller.
//   DEPTH   : SRAM locations (must equal 2**PTR_W)
//   WIDTH   : data word width
//   PTR_W   : SRAM address / pointer width
//   ptr_t   : SRAM address type
//   word_t  : data word type
//   level_t : occupancy type, wide enough for 0..DEPTH+2
package sram_fifo_pkg;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int PTR_W = 3;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [3:0]       level_t;
endpackage

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around a single-ported 8x32 SRAM
// with a one-cycle registered read. Each cycle issues exactly one SRAM
// operation (write or read). A read ("fetch") lands one cycle later in a
// one-entry output register that presents rd_data to the consumer.
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   wr_valid/wr_ready : producer handshake, wr_data is the word
//   rd_valid/rd_ready : consumer handshake, rd_data is the registered word
//   level             : SRAM entries + in-flight fetch + output register
//   full / empty      : SRAM holds DEPTH entries / level is zero
//   mem_address, mem_write_enable, mem_write_data : drive the SRAM
//   mem_read_data     : SRAM read data, valid the cycle after a read
import sram_fifo_pkg::*;

module sram_fifo_ctrl (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   wr_valid,
    output logic   wr_ready,
    input  word_t  wr_data,
    output logic   rd_valid,
    input  logic   rd_ready,
    output word_t  rd_data,
    output level_t level,
    output logic   full,
    output logic   empty,
    output ptr_t   mem_address,
    output logic   mem_write_enable,
    output word_t  mem_write_data,
    input  word_t  mem_read_data
);

    ptr_t   r_wr_ptr;
    ptr_t   r_rd_ptr;
    level_t r_count;
    logic   r_fetch_pending;
    logic   r_out_valid;
    word_t  r_out_data;

    logic   w_pop;
    logic   w_fetch;
    logic   w_push;
    logic   w_wr_ready;

    always_comb begin
        w_pop      = r_out_valid && rd_ready;
        // Only one fetch may be outstanding, and it may only be issued
        // when the output register is guaranteed free on landing.
        w_fetch    = !r_fetch_pending && (r_count != '0) && (!r_out_valid || w_pop);
        // Reads win the single SRAM port, so the producer stalls in fetch cycles.
        w_wr_ready = (r_count != level_t'(DEPTH)) && !w_fetch;
        // Gated by reset so no SRAM write can escape while reset_n is low.
        w_push     = wr_valid && w_wr_ready && reset_n;

        wr_ready         = w_wr_ready;
        rd_valid         = r_out_valid;
        rd_data          = r_out_data;
        level            = r_count + level_t'(r_fetch_pending) + level_t'(r_out_valid);
        full             = (r_count == level_t'(DEPTH));
        empty            = (level == '0);

        // Idle cycles issue a harmless read of rd_ptr whose data is ignored.
        mem_write_enable = 1'b0;
        mem_address      = r_rd_ptr;
        mem_write_data   = '0;
        if (w_push) begin
            mem_write_enable = 1'b1;
            mem_address      = r_wr_ptr;
            mem_write_data   = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_fetch_pending <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
        end else begin
            // Push and fetch are mutually exclusive, so count moves by at most one.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end else if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end

            r_fetch_pending <= w_fetch;

            if (r_fetch_pending) begin
                r_out_data  <= mem_read_data;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 8x32 SRAM
// (registered read, one-cycle latency). One line per failed comparison,
// one summary line at the end.
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   wr_valid;
    logic   wr_ready;
    word_t  wr_data;
    logic   rd_valid;
    logic   rd_ready;
    word_t  rd_data;
    level_t level;
    logic   full;
    logic   empty;
    ptr_t   mem_address;
    logic   mem_write_enable;
    word_t  mem_write_data;
    word_t  mem_read_data;

    always #5 clk = ~clk;

    sram_fifo_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .level            (level),
        .full             (full),
        .empty            (empty),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    // Behavioural single-ported SRAM, no reset.
    word_t mem [DEPTH];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
        mem_read_data <= mem[mem_address];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_rd_data"},  rd_data, 32'd0);
        check({tag, "_level"},    {28'd0, level}, 32'd0);
        check({tag, "_empty"},    {31'd0, empty}, 32'd1);
        check({tag, "_full"},     {31'd0, full}, 32'd0);
        check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
        check({tag, "_mem_we"},   {31'd0, mem_write_enable}, 32'd0);
        check({tag, "_mem_addr"}, {29'd0, mem_address}, 32'd0);
    endtask

    word_t sb[$];
    int    pushed;
    int    popped;
    int    exp_idx;

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = '0;
        cyc();
        cyc();
        // wr_valid high during reset must not produce an SRAM write
        wr_valid = 1'b1;
        wr_data  = 32'hFFFF_FFFF;
        #1;
        check_reset_outputs("rst");
        wr_valid = 1'b0;
        reset_n  = 1'b1;

        // ---- Fill with rd_ready=0: push, fetch stall, then 8 more pushes
        wr_valid = 1'b1;
        wr_data  = 32'hA5A5_0001;
        #1;
        check("A_c1_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("A_c1_mem_we",   {31'd0, mem_write_enable}, 32'd1);
        check("A_c1_addr",     {29'd0, mem_address}, 32'd0);
        check("A_c1_wdata",    mem_write_data, 32'hA5A5_0001);
        cyc();
        wr_data = 32'hA5A5_0002;
        #1;
        check("A_c2_fetch_stall", {31'd0, wr_ready}, 32'd0);
        check("A_c2_mem_we",      {31'd0, mem_write_enable}, 32'd0);
        check("A_c2_addr",        {29'd0, mem_address}, 32'd0);
        check("A_c2_level",       {28'd0, level}, 32'd1);
        cyc();
        for (int k = 2; k <= 9; k++) begin
            wr_data = 32'hA5A5_0000 + k;
            #1;
            check($sformatf("A_push%0d_wr_ready", k), {31'd0, wr_ready}, 32'd1);
            check($sformatf("A_push%0d_addr", k), {29'd0, mem_address}, (k - 1) % 8);
            cyc();
        end
        wr_valid = 1'b1;
        wr_data  = 32'hA5A5_000A;
        #1;
        check("A_full",     {31'd0, full}, 32'd1);
        check("A_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("A_mem_we",   {31'd0, mem_write_enable}, 32'd0);
        check("A_level",    {28'd0, level}, 32'd9);
        check("A_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("A_rd_data",  rd_data, 32'hA5A5_0001);

        // ---- Stall 5 cycles: output holds, nothing issued
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("S%0d_rd_data", i), rd_data, 32'hA5A5_0001);
            check($sformatf("S%0d_rd_valid", i), {31'd0, rd_valid}, 32'd1);
            check($sformatf("S%0d_mem_we", i), {31'd0, mem_write_enable}, 32'd0);
            check($sformatf("S%0d_level", i), {28'd0, level}, 32'd9);
        end
        wr_valid = 1'b0;

        // ---- Drain: one word every 2 cycles, in order
        rd_ready = 1'b1;
        exp_idx  = 1;
        for (int i = 0; i <= 16; i++) begin
            #1;
            check($sformatf("B%0d_rd_valid", i), {31'd0, rd_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (rd_valid) begin
                check($sformatf("B%0d_rd_data", i), rd_data, 32'hA5A5_0000 + exp_idx);
                exp_idx++;
            end
            cyc();
        end
        #1;
        check("B_words", exp_idx, 32'd10);
        check("B_empty", {31'd0, empty}, 32'd1);
        check("B_level", {28'd0, level}, 32'd0);

        // ---- Latency: push in N, rd_valid in N+3 (pointers now at 1)
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        #1;
        check("C_N_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("C_N_addr",     {29'd0, mem_address}, 32'd1);
        cyc();
        wr_valid = 1'b0;
        #1;
        check("C_N1_mem_we",   {31'd0, mem_write_enable}, 32'd0);
        check("C_N1_addr",     {29'd0, mem_address}, 32'd1);
        check("C_N1_rd_valid", {31'd0, rd_valid}, 32'd0);
        cyc();
        check("C_N2_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("C_N2_level",    {28'd0, level}, 32'd1);
        cyc();
        check("C_N3_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("C_N3_rd_data",  rd_data, 32'hDEAD_BEEF);
        cyc();
        check("C_empty", {31'd0, empty}, 32'd1);

        // ---- Continuous streaming of 20 words with pointer wrap
        pushed = 0;
        popped = 0;
        for (int i = 0; i < 300 && popped < 20; i++) begin
            wr_valid = (pushed < 20);
            wr_data  = 32'h5000_0000 + pushed;
            #1;
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("D_underflow", 32'd1, 32'd0);
                end else begin
                    check($sformatf("D_word%0d", popped), rd_data, sb[0]);
                    void'(sb.pop_front());
                end
                popped++;
            end
            if (wr_valid && wr_ready) begin
                sb.push_back(wr_data);
                pushed++;
            end
            cyc();
        end
        wr_valid = 1'b0;
        #1;
        check("D_pushed", pushed, 32'd20);
        check("D_popped", popped, 32'd20);
        check("D_empty",  {31'd0, empty}, 32'd1);

        // ---- Reset while a fetch is in flight
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'hCAFE_0001;
        cyc();
        wr_valid = 1'b0;
        cyc();
        check("F_pre_level", {28'd0, level}, 32'd1);
        wr_valid = 1'b1;
        reset_n  = 1'b0;
        #1;
        check_reset_outputs("F_rst");
        cyc();
        check("F_rst_edge_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("F_rst_edge_level",    {28'd0, level}, 32'd0);
        wr_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h1234_5678;
        #1;
        check("F_push_ready", {31'd0, wr_ready}, 32'd1);
        cyc();
        wr_valid = 1'b0;
        for (int i = 0; i < 10 && !rd_valid; i++) cyc();
        check("F_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("F_rd_data",  rd_data, 32'h1234_5678);
        cyc();
        check("F_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
